// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, memory depth.
package lsu_pkg;
  localparam int IDX_W = 11;
  localparam logic [IDX_W-1:0] MEM_WORDS = 11'd1028;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, MERGE, WRITE} state_e;

  function automatic logic f3_bad(input logic [2:0] f3);
    return f3 inside {3'b011, 3'b110, 3'b111};
  endfunction
endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: load lane select + sign/zero extend, and store lane merge.
module lsu_lane import lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = rword[{lane, 3'b000} +: 8];
    h      = lane[1] ? rword[31:16] : rword[15:0];
    ldata  = rword;
    merged = rword;
    case (funct3)
      F3_B:    ldata = {{24{b[7]}}, b};
      F3_BU:   ldata = {24'b0, b};
      F3_H:    ldata = {{16{h[15]}}, h};
      F3_HU:   ldata = {16'b0, h};
      default: ldata = rword;
    endcase
    // Stores only care about the size bits; the unsigned variants alias B/H.
    case (funct3[1:0])
      2'b00:   merged[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01:   if (lane[1]) merged[31:16] = wdata[15:0];
               else         merged[15:0]  = wdata[15:0];
      default: merged = wdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit with read-modify-write for sub-word stores.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned H/W accesses instead of force-aligning.
module load_store_unit import lsu_pkg::*; (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [31:0]       o_rdata,
  output logic              o_sdone,
  output logic              o_fault,
  output logic [IDX_W-1:0]  o_mem_addr,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);
  state_e             state;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        data_q;
  logic [2:0]         f3_q;
  logic [1:0]         lane_q;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         lane;
  logic               misalign, fault;
  logic [2:0]         sel_f3;
  logic [1:0]         sel_lane;
  logic [31:0]        ldata, merged;
  logic               unused_addr_hi;

  assign idx            = i_addr[12:2];
  assign unused_addr_hi = ^i_addr[31:13];

  always_comb begin
    lane     = i_addr[1:0];
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
               (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
`else
    if (i_funct3[1:0] == 2'b01)      lane[0] = 1'b0;
    else if (i_funct3[1:0] == 2'b10) lane    = 2'b00;
`endif
  end

  assign fault       = (idx >= MEM_WORDS) || f3_bad(i_funct3) || misalign;
  assign o_ready     = (state == IDLE);
  assign o_mem_addr  = (state == IDLE) ? idx : idx_q;
  assign o_mem_wdata = data_q;

  // One lane unit serves both the IDLE load path and the MERGE step.
  assign sel_f3   = (state == IDLE) ? i_funct3 : f3_q;
  assign sel_lane = (state == IDLE) ? lane : lane_q;

  lsu_lane u_lane (
    .funct3 (sel_f3),
    .lane   (sel_lane),
    .rword  (i_mem_rdata),
    .wdata  (data_q),
    .ldata  (ldata),
    .merged (merged)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      f3_q     <= '0;
      lane_q   <= '0;
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
      o_sdone  <= 1'b0;
      o_fault  <= 1'b0;
      o_mem_we <= 1'b0;
    end else begin
      o_rvalid <= 1'b0;
      o_sdone  <= 1'b0;
      o_fault  <= 1'b0;
      o_mem_we <= 1'b0;
      case (state)
        IDLE: if (i_valid && (i_MemRead || i_MemWrite)) begin
          if (fault) begin
            o_fault <= 1'b1;
            if (!i_MemWrite) o_rdata <= '0;
          end else if (i_MemWrite) begin
            idx_q  <= idx;
            data_q <= i_wdata;
            f3_q   <= i_funct3;
            lane_q <= lane;
            if (i_funct3[1:0] == 2'b10) begin
              state    <= WRITE;
              o_mem_we <= 1'b1;
              o_sdone  <= 1'b1;
            end else begin
              state <= MERGE;
            end
          end else begin
            o_rdata  <= ldata;
            o_rvalid <= 1'b1;
          end
        end
        MERGE: begin
          data_q   <= merged;
          state    <= WRITE;
          o_mem_we <= 1'b1;
          o_sdone  <= 1'b1;
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a behavioural data memory.
module tb_load_store_unit;
  logic        i_clk = 1'b0;
  logic        i_rstn, i_valid, i_MemRead, i_MemWrite;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_ready, o_rvalid, o_sdone, o_fault, o_mem_we;
  logic [31:0] o_rdata, o_mem_wdata, i_mem_rdata;
  logic [10:0] o_mem_addr;

  logic [31:0] mem [0:2047];
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 i_clk = ~i_clk;

  load_store_unit dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_MemRead(i_MemRead),
    .i_MemWrite(i_MemWrite), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_sdone(o_sdone),
    .o_fault(o_fault), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  assign i_mem_rdata = mem[o_mem_addr];

  always @(posedge i_clk) begin
    if (o_mem_we) begin
      mem[o_mem_addr] <= o_mem_wdata;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        fault, rvalid;
    logic [31:0] rdata;
    int          sdone_cyc;
    int          chk_idx;
    logic [31:0] chk_word;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic rd, logic wr, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] w, logic flt, logic rv,
                              logic [31:0] rdat, int sd, int ci, logic [31:0] cw);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = w;
    v.fault = flt; v.rvalid = rv; v.rdata = rdat; v.sdone_cyc = sd;
    v.chk_idx = ci; v.chk_word = cw;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rd, logic wr, logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    i_valid = 1'b1; i_MemRead = rd; i_MemWrite = wr; i_funct3 = f3; i_addr = a; i_wdata = w;
  endtask

  task automatic idle_in();
    i_valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
  endtask

  initial begin
    int sd_at, busy, wr0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[5]    = 32'h1122_3344;
    mem[1027] = 32'hA5A5_0001;
    i_rstn = 1'b0; idle_in(); i_funct3 = '0; i_addr = '0; i_wdata = '0;
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);

    chk("reset ready",  o_ready,  1);
    chk("reset rvalid", o_rvalid, 0);
    chk("reset rdata",  o_rdata,  0);
    chk("reset we",     o_mem_we, 0);
    chk("reset fault",  o_fault,  0);
    chk("reset sdone",  o_sdone,  0);

    // SW 0x10: write visible in the following cycle
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    @(negedge i_clk); idle_in();
    chk("sw we",    o_mem_we,    1);
    chk("sw addr",  o_mem_addr,  4);
    chk("sw wdata", o_mem_wdata, 32'hDEAD_BEEF);
    chk("sw sdone", o_sdone,     1);
    chk("sw ready", o_ready,     0);
    @(negedge i_clk);
    chk("sw mem4",  mem[4],      32'hDEAD_BEEF);

    vecs.push_back(mk("sb_0x11",   0,1,3'b000,32'h11,  32'h1234_5655,0,0,0,           2,4,   32'hDEAD_55EF));
    vecs.push_back(mk("lb_0x13",   1,0,3'b000,32'h13,  0,            0,1,32'hFFFF_FFDE,0,4,   32'hDEAD_55EF));
    vecs.push_back(mk("lbu_0x13",  1,0,3'b100,32'h13,  0,            0,1,32'h0000_00DE,0,4,   32'hDEAD_55EF));
    vecs.push_back(mk("lhu_0x12",  1,0,3'b101,32'h12,  0,            0,1,32'h0000_DEAD,0,4,   32'hDEAD_55EF));
    vecs.push_back(mk("lh_0x10",   1,0,3'b001,32'h10,  0,            0,1,32'h0000_55EF,0,4,   32'hDEAD_55EF));
    vecs.push_back(mk("lw_0x10",   1,0,3'b010,32'h10,  0,            0,1,32'hDEAD_55EF,0,4,   32'hDEAD_55EF));
    vecs.push_back(mk("sw_oob",    0,1,3'b010,32'h1010,32'h0BAD_0BAD,1,0,0,           0,1028,32'h0));
    vecs.push_back(mk("lw_last",   1,0,3'b010,32'h100C,0,            0,1,32'hA5A5_0001,0,1027,32'hA5A5_0001));
    vecs.push_back(mk("lw_oob",    1,0,3'b010,32'h1010,0,            1,0,32'h0,        0,1028,32'h0));
    vecs.push_back(mk("lw_reload", 1,0,3'b010,32'h10,  0,            0,1,32'hDEAD_55EF,0,4,   32'hDEAD_55EF));
    vecs.push_back(mk("ld_f3_011", 1,0,3'b011,32'h10,  0,            1,0,32'h0,        0,4,   32'hDEAD_55EF));
    vecs.push_back(mk("sh_0x16",   0,1,3'b001,32'h16,  32'h0000_BEEF,0,0,0,           2,5,   32'hBEEF_3344));
    vecs.push_back(mk("sb_f3_111", 0,1,3'b111,32'h14,  32'hFF,       1,0,0,           0,5,   32'hBEEF_3344));
    vecs.push_back(mk("rdwr_sw",   1,1,3'b010,32'h18,  32'h0102_0304,0,0,0,           1,6,   32'h0102_0304));
    vecs.push_back(mk("no_op",     0,0,3'b010,32'h18,  32'hFFFF_FFFF,0,0,0,           0,6,   32'h0102_0304));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lh_0x11",   1,0,3'b001,32'h11,  0,            1,0,32'h0,        0,4,   32'hDEAD_55EF));
    vecs.push_back(mk("lh_0x17",   1,0,3'b001,32'h17,  0,            1,0,32'h0,        0,5,   32'hBEEF_3344));
    vecs.push_back(mk("sw_0x12",   0,1,3'b010,32'h12,  32'hCAFE_F00D,1,0,0,           0,4,   32'hDEAD_55EF));
`else
    vecs.push_back(mk("lh_0x11",   1,0,3'b001,32'h11,  0,            0,1,32'h0000_55EF,0,4,   32'hDEAD_55EF));
    vecs.push_back(mk("lh_0x17",   1,0,3'b001,32'h17,  0,            0,1,32'hFFFF_BEEF,0,5,   32'hBEEF_3344));
    vecs.push_back(mk("sw_0x12",   0,1,3'b010,32'h12,  32'hCAFE_F00D,0,0,0,           1,4,   32'hCAFE_F00D));
`endif

    foreach (vecs[k]) begin
      wr0 = wr_cnt;
      drive(vecs[k].rd, vecs[k].wr, vecs[k].f3, vecs[k].addr, vecs[k].wdata);
      @(negedge i_clk); idle_in();
      chk({vecs[k].name, " fault"},  o_fault,  vecs[k].fault);
      chk({vecs[k].name, " rvalid"}, o_rvalid, vecs[k].rvalid);
      if (vecs[k].rd && !vecs[k].wr && (vecs[k].rvalid || vecs[k].fault))
        chk({vecs[k].name, " rdata"}, o_rdata, vecs[k].rdata);
      sd_at = 0; busy = 0;
      for (int c = 1; c <= 3; c++) begin
        if (c > 1) @(negedge i_clk);
        if (o_sdone && sd_at == 0) sd_at = c;
        if (!o_ready) busy++;
      end
      chk({vecs[k].name, " sdone_cyc"}, sd_at, vecs[k].sdone_cyc);
      chk({vecs[k].name, " busy"},      busy,  vecs[k].sdone_cyc);
      chk({vecs[k].name, " writes"},    wr_cnt - wr0, (vecs[k].sdone_cyc != 0) ? 1 : 0);
      chk({vecs[k].name, " mem"},       mem[vecs[k].chk_idx], vecs[k].chk_word);
    end

    // back-to-back loads, one per cycle
    drive(1'b1, 1'b0, 3'b010, 32'h100C, 0);
    @(negedge i_clk);
    chk("b2b ready", o_ready, 1);
    chk("b2b rv1",   o_rvalid, 1);
    chk("b2b rd1",   o_rdata,  32'hA5A5_0001);
    drive(1'b1, 1'b0, 3'b001, 32'h1A, 0);
    @(negedge i_clk); idle_in();
    chk("b2b rv2",   o_rvalid, 1);
    chk("b2b rd2",   o_rdata,  32'h0000_0102);
    @(negedge i_clk);
    chk("b2b rv_end", o_rvalid, 0);

    // reset while an SB sits in MERGE
    wr0 = wr_cnt;
    drive(1'b0, 1'b1, 3'b000, 32'h14, 32'h99);
    @(negedge i_clk); idle_in();
    chk("rst merge busy", o_ready, 0);
    i_rstn = 1'b0;
    #1;
    chk("rst we",    o_mem_we, 0);
    chk("rst ready", o_ready,  1);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("rst writes", wr_cnt - wr0, 0);
    chk("rst mem5",   mem[5], 32'hBEEF_3344);
    chk("rst sdone",  o_sdone, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_valid, input, 1, request present from the execute stage.
REQ-004 SHALL have port i_MemRead, input, 1, load request.
REQ-005 SHALL have port i_MemWrite, input, 1, store request.
REQ-006 SHALL have port i_funct3, input, 3, RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port i_addr, input, 32, byte address.
REQ-008 SHALL have port i_wdata, input, 32, store data, right-aligned.
REQ-009 SHALL have port o_ready, output, 1, request accepted when i_valid && o_ready.
REQ-010 SHALL have port o_rvalid, output, 1, one-cycle pulse marking valid o_rdata.
REQ-011 SHALL have port o_rdata, output, 32, extended load result.
REQ-012 SHALL have port o_sdone, output, 1, one-cycle pulse in the cycle the store is written.
REQ-013 SHALL have port o_fault, output, 1, one-cycle pulse for a rejected access.
REQ-014 SHALL have port o_mem_addr, output, 11, word address to data memory.
REQ-015 SHALL have port o_mem_we, output, 1, memory write enable.
REQ-016 SHALL have port o_mem_wdata, output, 32, memory write word.
REQ-017 SHALL have port i_mem_rdata, input, 32, combinational memory read word.

Function
REQ-018 SHALL implement FSM states IDLE, MERGE, WRITE; o_ready=1 only in IDLE.
REQ-019 SHALL derive the word index as i_addr[12:2] and the byte lane as i_addr[1:0].
REQ-020 SHALL drive o_mem_addr from i_addr in IDLE and from the latched index in MERGE/WRITE.
REQ-021 SHALL, for an accepted load in cycle N, register the selected lane extended per funct3 into o_rdata and pulse o_rvalid in N+1; FSM stays IDLE, so back-to-back loads are accepted every cycle.
REQ-022 SHALL, for an accepted SW, latch index and data, go IDLE->WRITE, and assert o_mem_we with o_sdone in N+1, then return to IDLE.
REQ-023 SHALL, for an accepted SB/SH, go IDLE->MERGE->WRITE: in MERGE, read i_mem_rdata and replace the target byte/halfword lane; in WRITE (N+2), write the merged word with o_mem_we and o_sdone.
REQ-024 SHALL give store priority when i_MemRead and i_MemWrite are both set; o_rvalid stays 0.
REQ-025 SHALL reject any word index >= MEM_WORDS (1028): no write, o_fault pulse in N+1, load o_rdata=0.
REQ-026 SHALL treat i_funct3 values 011, 110, 111 as faults with the same behaviour as REQ-025.
REQ-027 SHALL ignore i_valid with neither i_MemRead nor i_MemWrite set.
REQ-028 SHALL keep o_mem_we=0 in IDLE and MERGE.

Reset
REQ-029 SHALL on !i_rstn enter IDLE, clear o_rdata, o_rvalid, o_sdone, o_fault and the latched index/data, and drive o_mem_we=0 immediately.
REQ-030 SHALL abort a store in MERGE/WRITE on reset without writing memory.

Configuration
REQ-031 SHALL, with LSU_MISALIGN_TRAP_EN defined, fault (REQ-025 behaviour) a halfword with i_addr[0]=1 or a word with i_addr[1:0]!=0.
REQ-032 SHALL, without LSU_MISALIGN_TRAP_EN, force alignment by clearing the offending low address bits and never fault for misalignment.

Structure
REQ-033 SHALL place the funct3 encodings, the state enum and MEM_WORDS=1028 in package lsu_pkg.
REQ-034 SHALL put lane select/extend and lane merge in one combinational sub-module lsu_lane.

Verification
REQ-035 SHALL check: SW addr 0x10, data 0xDEADBEEF -> o_mem_we=1, o_mem_addr=4, o_mem_wdata=0xDEADBEEF in N+1.
REQ-036 SHALL check: memory word 4 holds 0xDEADBEEF, SB addr 0x11, data 0x55 -> o_ready low 2 cycles, write 0xDEAD55EF at N+2.
REQ-037 SHALL check: LB addr 0x13 over 0xDEAD55EF -> o_rdata=0xFFFFFFDE; LBU -> 0x000000DE; LHU addr 0x12 -> 0x0000DEAD.
REQ-038 SHALL check: SW addr 0x1010 (index 1028) -> o_fault pulse, o_mem_we never 1.
REQ-039 SHALL check: LH addr 0x11 -> o_fault with LSU_MISALIGN_TRAP_EN; without it, o_rdata from lane 0.
REQ-040 SHALL check: reset asserted in MERGE of an SB -> o_mem_we stays 0 and the memory word is unchanged.
